oam_dma: RTL and testbench

Sprite-DMA engine on the CPU data bus, directly downstream of `cpu`. It snoops CPU writes. A write to $4014 stalls the CPU and copies one 256-byte page, $XX00-$XXFF, into PPU OAM through $2004. While active, the block owns the address/data bus; the top-level bus mux selects its outputs whenever `dma_active` is high.

---
 rtl/nes_pkg.sv | 15 +
 rtl/oam_dma.sv | 92 +++++++++
 tb/tb_oam_dma.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
// Shared NES bus constants and the sprite-DMA state encoding.
package nes_pkg;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to $4014 halts the CPU and copies page $XX00-$XXFF
// into OAM through $2004, one read/write pair per byte, reads on get cycles.
module oam_dma
  import nes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_we,
  input  logic [7:0]  bus_d_in,
  output logic        cpu_halt,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_d_out,
  output logic        dma_we
);

  dma_state_t state_q, state_d;
  logic       odd_q, odd_d;
  logic [7:0] page_q, page_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] latch_q, latch_d;
  logic       trigger;

  // Triggers are only honoured from IDLE; writes during a transfer are dropped.
  assign trigger = (state_q == IDLE) && cpu_we && (cpu_addr == ADDR_OAMDMA);

  // State register and datapath flops; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      odd_q   <= 1'b0;
      page_q  <= 8'h00;
      cnt_q   <= 8'h00;
      latch_q <= 8'h00;
    end else begin
      state_q <= state_d;
      odd_q   <= odd_d;
      page_q  <= page_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
    end
  end

  // Next-state: HALT lets the CPU write finish, ALIGN pushes READ onto a get cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (trigger) state_d = HALT;
      HALT:    state_d = odd_q ? READ : ALIGN;
      ALIGN:   state_d = READ;
      READ:    state_d = WRITE;
      WRITE:   state_d = (cnt_q == 8'hFF) ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: parity free-runs, page/cnt load on trigger, byte captured in READ.
  always_comb begin
    odd_d   = ~odd_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    if (trigger) begin
      page_d = cpu_d_out;
      cnt_d  = 8'h00;
    end
    if (state_q == READ)  latch_d = bus_d_in;
    if (state_q == WRITE) cnt_d   = cnt_q + 8'h01;
  end

  // Outputs decode from registered state only; bus_d_in never reaches them directly.
  always_comb begin
    cpu_halt  = (state_q != IDLE);
    dma_addr  = 16'h0000;
    dma_d_out = 8'h00;
    dma_we    = 1'b0;
    case (state_q)
      READ:  dma_addr = {page_q, cnt_q};
      WRITE: begin
        dma_addr  = ADDR_OAMDATA;
        dma_d_out = latch_q;
        dma_we    = 1'b1;
      end
      default: ;
    endcase
  end

  assign dma_active = cpu_halt;

endmodule

// File: tb/tb_oam_dma.sv
// Randomised bench for oam_dma: a behavioural memory plus per-transfer
// expectations (byte order, halt length from edge parity, get-cycle reads).
module tb_oam_dma;
  import nes_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_d_out = 8'h00;
  logic        cpu_we = 1'b0;
  logic [7:0]  bus_d_in;
  logic        cpu_halt, dma_active, dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_d_out;

  logic [7:0]  mem [0:65535];
  int          cyc;
  int          n_tests = 0;
  int          n_fail  = 0;

  oam_dma dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out),
    .cpu_we(cpu_we), .bus_d_in(bus_d_in), .cpu_halt(cpu_halt),
    .dma_active(dma_active), .dma_addr(dma_addr), .dma_d_out(dma_d_out),
    .dma_we(dma_we)
  );

  always #5 clk = ~clk;

  assign bus_d_in = mem[dma_addr];

  // Edges since reset; during a cycle the DMA parity is cyc%2.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_halt"}, {31'd0, cpu_halt}, 0);
    chk({tag, "_act"},  {31'd0, dma_active}, 0);
    chk({tag, "_we"},   {31'd0, dma_we}, 0);
    chk({tag, "_addr"}, {16'd0, dma_addr}, 0);
    chk({tag, "_dout"}, {24'd0, dma_d_out}, 0);
  endtask

  // Called at a negedge. want: -1 any, 0/1 = required parity in the HALT cycle.
  // inj_at: write index at which a stray $4014 write is forced (-1 none).
  // rst_at: write index at which reset is pulsed (-1 none).
  task automatic run_xfer(input logic [7:0] pg, input int want, input int inj_at, input int rst_at);
    int          halt_n = 0, nwr = 0, exp_len, n;
    bit          done = 0, injd = 0;
    logic [15:0] prev_addr, ea;
    int          prev_odd;
    while (want >= 0 && ((cyc + 1) % 2) != want) @(negedge clk);
    cpu_addr = ADDR_OAMDMA; cpu_d_out = pg; cpu_we = 1'b1;
    @(posedge clk); #1;
    n = cyc;
    exp_len = (n % 2) ? 513 : 514;
    cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_d_out = 8'h00;
    chk("halt_rise", {31'd0, cpu_halt}, 1);
    prev_addr = 16'h0000; prev_odd = 1;
    for (int k = 0; k < 1200 && !done; k++) begin
      @(negedge clk);
      cpu_we = 1'b0;
      if (inj_at >= 0 && nwr == inj_at && !injd) begin
        cpu_addr = ADDR_OAMDMA; cpu_d_out = 8'h07; cpu_we = 1'b1; injd = 1;
      end
      chk("active_eq_halt", {31'd0, dma_active}, {31'd0, cpu_halt});
      if (dma_we) begin
        ea = {pg, 8'(nwr)};
        chk("wr_addr", {16'd0, dma_addr}, {16'd0, ADDR_OAMDATA});
        chk("rd_addr", {16'd0, prev_addr}, {16'd0, ea});
        chk("wr_data", {24'd0, dma_d_out}, {24'd0, mem[ea]});
        chk("rd_get_cycle", prev_odd, 0);
        if (nwr == rst_at) begin
          rst = 1'b1; #1;
          chk_idle("rst_mid");
          @(negedge clk); rst = 1'b0; cpu_we = 1'b0;
          return;
        end
        nwr++;
      end else if (!cpu_halt || halt_n == 0) begin
        chk("idle_addr", {16'd0, dma_addr}, 0);
      end
      if (cpu_halt) halt_n++;
      else if (halt_n > 0) done = 1;
      prev_addr = dma_addr;
      prev_odd  = cyc % 2;
    end
    cpu_we = 1'b0; cpu_addr = 16'h0000;
    chk("xfer_done", {31'd0, done}, 1);
    chk("n_writes", nwr, 256);
    chk("halt_len", halt_n, exp_len);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'hA5;
    #1;
    chk_idle("reset");
    repeat (3) @(negedge clk);
    chk_idle("reset_hold");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    run_xfer(8'h02, 1, -1, -1);          // entry on odd: no ALIGN, 513
    run_xfer(8'h02, 0, -1, -1);          // shifted by one: ALIGN, 514
    run_xfer(8'hFF, -1, -1, -1);         // page wrap boundary
    repeat (3) begin
      @(negedge clk);
      chk_idle("after_ff");
    end
    run_xfer(8'h31, -1, 40, -1);         // stray $4014 write mid-transfer
    run_xfer(8'h12, -1, -1, 100);        // reset at write #100
    chk_idle("after_rst");
    run_xfer(8'h12, -1, -1, -1);         // restart from cnt=0
    run_xfer(8'h05, -1, -1, -1);         // back-to-back pair
    chk("gap_low", {31'd0, cpu_halt}, 0);
    run_xfer(8'h06, -1, -1, -1);

    for (int t = 0; t < 4; t++) begin
      logic [7:0] pg;
      pg = 8'($urandom_range(0, 255));
      for (int j = 0; j < 256; j++) mem[{pg, 8'(j)}] = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_xfer(pg, int'($urandom_range(0, 1)),
               ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 255)) : -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
